// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares the single UART TX byte stream among NUM_REQ byte-stream requesters.
// A grant is held for a whole packet (until a byte flagged req_last) or until
// MAX_BURST bytes have gone through, whichever comes first. Arbitration is
// round-robin, starting one past the most recently released requester.
// The outgoing byte sits in a one-deep register that can be refilled in the
// same cycle it is drained, so a granted requester can stream 1 byte/cycle.

module uart_tx_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 16
) (
   input  logic                         ACLK,
   input  logic                         ARESETN,
   input  logic                         enable,
   input  logic [NUM_REQ*DATA_W-1:0]    req_data,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ-1:0]           req_last,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [DATA_W-1:0]            tx_data,
   output logic                         tx_valid,
   input  logic                         tx_ready,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic                         busy
);

   localparam int ID_W = $clog2(NUM_REQ);

   // Parameter sanity: out-of-range values would silently break the counters.
   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
   end
   if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
      $error("uart_tx_arbiter: MAX_BURST must be in 1..255");
   end
   if (DATA_W < 1) begin : g_bad_data_w
      $error("uart_tx_arbiter: DATA_W must be at least 1");
   end

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t              state_q,     state_d;
   logic [ID_W-1:0]     grant_q,     grant_d;
   logic [ID_W-1:0]     rr_ptr_q,    rr_ptr_d;
   logic [7:0]          burst_cnt_q, burst_cnt_d;
   logic [DATA_W-1:0]   tx_data_q,   tx_data_d;
   logic                tx_valid_q,  tx_valid_d;

   // Arbitration result and granted-lane view of the request bus.
   logic                pick_found;
   logic [ID_W-1:0]     pick_id;
   logic                sel_valid;
   logic                sel_last;
   logic [DATA_W-1:0]   sel_data;
   logic                slot_free;
   logic                xfer;

   // Next requester index, wrapping explicitly so that non-power-of-2
   // NUM_REQ never lands on an unused code.
   function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx);
      if (idx == ID_W'(NUM_REQ - 1)) begin
         return '0;
      end
      return idx + 1'b1;
   endfunction

   // True when the byte being transferred now is the last one this grant may
   // carry. Done in 9 bits so MAX_BURST=255 cannot alias through overflow.
   function automatic logic burst_done(input logic [7:0] cnt);
      return ({1'b0, cnt} + 9'd1) == 9'(MAX_BURST);
   endfunction

   // Round-robin pick: first valid requester scanning upward from rr_ptr.
   always_comb begin
      logic [ID_W-1:0] cand;
      cand       = rr_ptr_q;
      pick_found = 1'b0;
      pick_id    = rr_ptr_q;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!pick_found && req_valid[cand]) begin
            pick_found = 1'b1;
            pick_id    = cand;
         end
         cand = wrap_inc(cand);
      end
   end

   // Mux out the granted requester's valid, last flag and data byte.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q == ID_W'(i)) begin
            sel_valid = req_valid[i];
            sel_last  = req_last[i];
            sel_data  = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Handshake towards the requesters: only the granted lane may be ready,
   // and only when the output register is empty or draining this cycle.
   always_comb begin
      slot_free = !tx_valid_q || tx_ready;
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (state_q == ST_GRANT && grant_q == ID_W'(i)) begin
            req_ready[i] = slot_free;
         end
      end
      xfer = (state_q == ST_GRANT) && sel_valid && slot_free;
   end

   // Next-state logic for the FSM, burst counter and output byte register.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;

      // A new byte overwrites the register even while the old one is being
      // taken, which is what removes the bubble between back-to-back bytes.
      if (xfer) begin
         tx_data_d  = sel_data;
         tx_valid_d = 1'b1;
      end else if (tx_ready) begin
         tx_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            // A byte may still be draining here; granting anyway is safe
            // because the new lane's req_ready waits on tx_ready.
            if (enable && pick_found) begin
               grant_d     = pick_id;
               burst_cnt_d = '0;
               state_d     = ST_GRANT;
            end
         end
         ST_GRANT: begin
            // The grant is held while the owner stalls; only a transfer can
            // end it. enable is deliberately ignored so packets complete.
            if (xfer) begin
               burst_cnt_d = burst_cnt_q + 8'd1;
               if (sel_last || burst_done(burst_cnt_q)) begin
                  state_d  = ST_IDLE;
                  rr_ptr_d = wrap_inc(grant_q);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register; reset drops any in-flight byte and the grant at once.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
         tx_data_q   <= '0;
         tx_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
      end
   end

   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign grant_id = grant_q;
   assign busy     = (state_q == ST_GRANT);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed cycle-level scenarios followed by
// randomized packet traffic scored against a packet-level arbitration model.

module tb_uart_tx_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int DATA_W    = 8;
   localparam int MAX_BURST = 16;

   logic                        ACLK;
   logic                        ARESETN;
   logic                        enable;
   logic [NUM_REQ*DATA_W-1:0]   req_data;
   logic [NUM_REQ-1:0]          req_valid;
   logic [NUM_REQ-1:0]          req_last;
   logic [NUM_REQ-1:0]          req_ready;
   logic [DATA_W-1:0]           tx_data;
   logic                        tx_valid;
   logic                        tx_ready;
   logic [1:0]                  grant_id;
   logic                        busy;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   // Per-requester byte lists: bit 8 = last flag, bits 7:0 = data.
   logic [8:0]  pk_mem  [NUM_REQ][256];
   int          pk_len  [NUM_REQ];
   int          pk_head [NUM_REQ];

   // Expected output stream derived from the arbitration rules.
   int          exp_id   [1024];
   logic [7:0]  exp_byte [1024];
   int          exp_n;

   uart_tx_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .DATA_W    (DATA_W),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .ACLK      (ACLK),
      .ARESETN   (ARESETN),
      .enable    (enable),
      .req_data  (req_data),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_ready (req_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic set_lane(input int r, input logic v, input logic [7:0] d, input logic l);
      req_valid[r]          = v;
      req_data[r*8 +: 8]    = d;
      req_last[r]           = l;
   endtask

   task automatic do_reset();
      ARESETN   = 1'b0;
      enable    = 1'b0;
      tx_ready  = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      ARESETN = 1'b1;
   endtask

   task automatic clear_pkts();
      for (int r = 0; r < NUM_REQ; r++) begin
         pk_len[r]  = 0;
         pk_head[r] = 0;
      end
   endtask

   task automatic add_pkt(input int r, input int len);
      for (int b = 0; b < len; b++) begin
         pk_mem[r][pk_len[r]] = {(b == len - 1), 8'($urandom_range(0, 255))};
         pk_len[r]++;
      end
   endtask

   task automatic drive_reqs();
      for (int r = 0; r < NUM_REQ; r++) begin
         if (pk_head[r] < pk_len[r]) begin
            set_lane(r, 1'b1, pk_mem[r][pk_head[r]][7:0], pk_mem[r][pk_head[r]][8]);
         end else begin
            set_lane(r, 1'b0, 8'h00, 1'b0);
         end
      end
   endtask

   // Packet-level model: every requester with bytes left is assumed to be
   // requesting, so the service order follows from the round-robin rules alone.
   task automatic build_expected();
      int head [NUM_REQ];
      int rr;
      int g;
      int cnt;
      logic [8:0] ent;
      for (int r = 0; r < NUM_REQ; r++) head[r] = 0;
      rr    = 0;
      exp_n = 0;
      while (1) begin
         g = -1;
         for (int k = 0; k < NUM_REQ; k++) begin
            if (g < 0 && head[(rr + k) % NUM_REQ] < pk_len[(rr + k) % NUM_REQ])
               g = (rr + k) % NUM_REQ;
         end
         if (g < 0) break;
         cnt = 0;
         ent = 9'h0;
         while (head[g] < pk_len[g] && !ent[8] && cnt < MAX_BURST) begin
            ent = pk_mem[g][head[g]];
            head[g]++;
            exp_id[exp_n]   = g;
            exp_byte[exp_n] = ent[7:0];
            exp_n++;
            cnt++;
         end
         rr = (g + 1) % NUM_REQ;
      end
   endtask

   task automatic run_engine(input string name, input int rdy_pct, input int en_pct);
      int a_idx;
      int o_idx;
      int cyc;
      logic [NUM_REQ-1:0] acc;
      build_expected();
      do_reset();
      drive_reqs();
      tx_ready = (int'($urandom_range(0, 99)) < rdy_pct);
      enable   = (int'($urandom_range(0, 99)) < en_pct);
      a_idx = 0;
      o_idx = 0;
      cyc   = 0;
      while (o_idx < exp_n && cyc < 4000) begin
         @(negedge ACLK);
         acc = req_valid & req_ready;
         for (int r = 0; r < NUM_REQ; r++) begin
            if (acc[r]) begin
               if (a_idx < exp_n) chk({name, "_acc_id"}, 32'(r), 32'(exp_id[a_idx]));
               else               chk({name, "_acc_extra"}, 32'(a_idx), 32'(exp_n - 1));
               a_idx++;
            end
         end
         if (tx_valid && tx_ready) begin
            chk({name, "_tx_byte"}, 32'(tx_data), 32'(exp_byte[o_idx]));
            o_idx++;
         end
         @(posedge ACLK);
         #1;
         for (int r = 0; r < NUM_REQ; r++) if (acc[r]) pk_head[r]++;
         drive_reqs();
         tx_ready = (int'($urandom_range(0, 99)) < rdy_pct);
         enable   = (int'($urandom_range(0, 99)) < en_pct);
         cyc++;
      end
      chk({name, "_out_count"}, 32'(o_idx), 32'(exp_n));
      chk({name, "_acc_count"}, 32'(a_idx), 32'(exp_n));
      tx_ready = 1'b1;
      repeat (3) @(posedge ACLK);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ARESETN   = 1'b0;
      enable    = 1'b0;
      tx_ready  = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      clear_pkts();

      // ---------------- reset values ----------------
      do_reset();
      @(negedge ACLK);
      chk("rst_tx_valid",  32'(tx_valid),  32'd0);
      chk("rst_tx_data",   32'(tx_data),   32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_grant_id",  32'(grant_id),  32'd0);
      chk("rst_busy",      32'(busy),      32'd0);

      // ---------------- single requester, 41 42 43 ----------------
      enable   = 1'b1;
      tx_ready = 1'b1;
      @(posedge ACLK); #1;
      set_lane(0, 1'b1, 8'h41, 1'b0);                         // cycle 0
      @(negedge ACLK);
      chk("s1_c0_tx_valid", 32'(tx_valid), 32'd0);
      chk("s1_c0_busy",     32'(busy),     32'd0);
      @(posedge ACLK); #1;                                     // cycle 1
      @(negedge ACLK);
      chk("s1_c1_busy",      32'(busy),      32'd1);
      chk("s1_c1_req_ready", 32'(req_ready), 32'b0001);
      chk("s1_c1_tx_valid",  32'(tx_valid),  32'd0);
      @(posedge ACLK); #1;                                     // cycle 2
      set_lane(0, 1'b1, 8'h42, 1'b0);
      @(negedge ACLK);
      chk("s1_c2_tx_valid", 32'(tx_valid), 32'd1);
      chk("s1_c2_tx_data",  32'(tx_data),  32'h41);
      chk("s1_c2_grant_id", 32'(grant_id), 32'd0);
      @(posedge ACLK); #1;                                     // cycle 3
      set_lane(0, 1'b1, 8'h43, 1'b1);
      @(negedge ACLK);
      chk("s1_c3_tx_data", 32'(tx_data), 32'h42);
      chk("s1_c3_busy",    32'(busy),    32'd1);
      @(posedge ACLK); #1;                                     // cycle 4
      set_lane(0, 1'b0, 8'h00, 1'b0);
      @(negedge ACLK);
      chk("s1_c4_tx_data",   32'(tx_data),   32'h43);
      chk("s1_c4_tx_valid",  32'(tx_valid),  32'd1);
      chk("s1_c4_busy",      32'(busy),      32'd0);
      chk("s1_c4_req_ready", 32'(req_ready), 32'd0);
      @(posedge ACLK); #1;
      @(negedge ACLK);
      chk("s1_c5_tx_valid", 32'(tx_valid), 32'd0);

      // ---------------- backpressure on requester 2 ----------------
      @(posedge ACLK); #1;
      set_lane(2, 1'b1, 8'h55, 1'b0);                          // cycle 0
      @(posedge ACLK); #1;                                     // cycle 1: grant
      @(negedge ACLK);
      chk("bp_grant_id", 32'(grant_id), 32'd2);
      @(posedge ACLK); #1;                                     // 0x55 taken
      set_lane(2, 1'b1, 8'h56, 1'b0);
      tx_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge ACLK);
         chk("bp_hold_data",  32'(tx_data),   32'h55);
         chk("bp_hold_valid", 32'(tx_valid),  32'd1);
         chk("bp_hold_ready", 32'(req_ready), 32'd0);
         @(posedge ACLK); #1;
      end
      tx_ready = 1'b1;
      @(negedge ACLK);
      chk("bp_resume_ready", 32'(req_ready), 32'b0100);
      @(posedge ACLK); #1;
      set_lane(2, 1'b1, 8'h57, 1'b1);
      @(negedge ACLK);
      chk("bp_next_data", 32'(tx_data), 32'h56);
      @(posedge ACLK); #1;
      set_lane(2, 1'b0, 8'h00, 1'b0);
      @(negedge ACLK);
      chk("bp_last_data", 32'(tx_data), 32'h57);
      chk("bp_release",   32'(busy),    32'd0);
      @(posedge ACLK); #1;

      // ---------------- enable dropped mid-packet ----------------
      set_lane(3, 1'b1, 8'hA0, 1'b0);                          // cycle 0
      @(posedge ACLK); #1;                                     // cycle 1
      @(posedge ACLK); #1;                                     // cycle 2
      set_lane(3, 1'b1, 8'hA1, 1'b0);
      @(posedge ACLK); #1;                                     // cycle 3
      enable = 1'b0;
      set_lane(3, 1'b1, 8'hA2, 1'b0);
      set_lane(0, 1'b1, 8'hB0, 1'b1);
      @(negedge ACLK);
      chk("en_busy_held", 32'(busy),    32'd1);
      chk("en_data_a1",   32'(tx_data), 32'hA1);
      @(posedge ACLK); #1;                                     // cycle 4
      set_lane(3, 1'b1, 8'hA3, 1'b1);
      @(negedge ACLK);
      chk("en_data_a2", 32'(tx_data), 32'hA2);
      @(posedge ACLK); #1;                                     // cycle 5
      set_lane(3, 1'b0, 8'h00, 1'b0);
      @(negedge ACLK);
      chk("en_data_a3", 32'(tx_data), 32'hA3);
      chk("en_done",    32'(busy),    32'd0);
      for (int c = 0; c < 4; c++) begin
         @(posedge ACLK); #1;
         @(negedge ACLK);
         chk("en_off_idle",  32'(busy),      32'd0);
         chk("en_off_ready", 32'(req_ready), 32'd0);
      end
      @(posedge ACLK); #1;
      enable = 1'b1;
      @(posedge ACLK); #1;
      @(negedge ACLK);
      chk("en_on_busy",  32'(busy),      32'd1);
      chk("en_on_grant", 32'(grant_id),  32'd0);
      chk("en_on_ready", 32'(req_ready), 32'b0001);
      @(posedge ACLK); #1;
      set_lane(0, 1'b0, 8'h00, 1'b0);
      @(negedge ACLK);
      chk("en_b0_data", 32'(tx_data), 32'hB0);

      // ---------------- asynchronous reset mid-packet ----------------
      @(posedge ACLK); #1;
      set_lane(1, 1'b1, 8'hC0, 1'b0);                          // cycle 0
      @(posedge ACLK); #1;                                     // cycle 1
      @(posedge ACLK); #1;                                     // cycle 2
      set_lane(1, 1'b1, 8'hC1, 1'b0);
      tx_ready = 1'b0;
      @(negedge ACLK);
      chk("ar_pre_valid", 32'(tx_valid), 32'd1);
      chk("ar_pre_grant", 32'(grant_id), 32'd1);
      @(posedge ACLK);
      #2;
      ARESETN = 1'b0;
      #1;
      chk("ar_tx_valid",  32'(tx_valid),  32'd0);
      chk("ar_tx_data",   32'(tx_data),   32'd0);
      chk("ar_req_ready", 32'(req_ready), 32'd0);
      chk("ar_busy",      32'(busy),      32'd0);
      chk("ar_grant_id",  32'(grant_id),  32'd0);
      set_lane(1, 1'b0, 8'h00, 1'b0);
      set_lane(3, 1'b1, 8'hD3, 1'b1);
      set_lane(0, 1'b1, 8'hD0, 1'b1);
      tx_ready = 1'b1;
      @(negedge ACLK);
      ARESETN = 1'b1;
      @(posedge ACLK); #1;
      @(negedge ACLK);
      chk("ar_first_grant", 32'(grant_id),  32'd0);
      chk("ar_first_ready", 32'(req_ready), 32'b0001);
      req_valid = '0;
      req_last  = '0;

      // ---------------- model-scored traffic ----------------
      clear_pkts();
      for (int r = 0; r < NUM_REQ; r++) begin
         add_pkt(r, 1);
         add_pkt(r, 1);
      end
      run_engine("rr", 100, 100);

      clear_pkts();
      add_pkt(1, 40);
      add_pkt(2, 3);
      run_engine("burst", 100, 100);

      for (int s = 0; s < 4; s++) begin
         clear_pkts();
         for (int r = 0; r < NUM_REQ; r++) begin
            int npk;
            npk = int'($urandom_range(0, 3));
            for (int p = 0; p < npk; p++) add_pkt(r, int'($urandom_range(1, 20)));
         end
         add_pkt(int'($urandom_range(0, NUM_REQ - 1)), int'($urandom_range(17, 20)));
         run_engine("rand", 70, 85);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares the single UART TX byte stream (uart_top data_cpu_tx / valid / ready) among NUM_REQ byte-stream requesters, e.g. CPU register path, DMA and debug console.
- Grants are packet-locked: a requester holds the UART until it sends a byte with req_last, or until MAX_BURST bytes have been sent.
- The output byte is registered; the block sits between the requesters and the uart_top TX interface.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_W, 8: byte width.
- MAX_BURST, 16: maximum bytes per grant before forced rotation (1..255).

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  reset, asynchronous, active-low.
- enable  in  1  1 = new grants allowed.
- req_data  in  NUM_REQ*DATA_W  byte from requester i, at slice [i*DATA_W +: DATA_W].
- req_valid  in  NUM_REQ  requester i byte valid.
- req_last  in  NUM_REQ  requester i byte is the last of its packet.
- req_ready  out  NUM_REQ  byte accepted from requester i.
- tx_data  out  DATA_W  byte to uart_top data_cpu_tx.
- tx_valid  out  1  to data_cpu_tx_valid.
- tx_ready  in  1  from data_cpu_tx_ready.
- grant_id  out  clog2(NUM_REQ)  index of the current or most recent grant.
- busy  out  1  1 while in the GRANT state.

Behaviour:
- Clocking and reset:
  - Clock is ACLK. Reset is ARESETN, asynchronous, active-low.
  - Reset values: tx_valid=0, tx_data=0, req_ready=0, grant_id=0, busy=0, rr_ptr=0, burst_cnt=0, state=IDLE.
  - Reset asserted mid-packet drops the in-flight byte and the grant immediately.
- States: IDLE, GRANT.
- IDLE:
  - req_ready=0.
  - If enable=1 and any req_valid=1, pick the first set bit searching upward from rr_ptr with wrap-around.
  - Register grant_id, clear burst_cnt, go to GRANT.
  - Arbitration costs exactly 1 cycle.
  - If enable=0 or no req_valid, stay in IDLE.
- GRANT:
  - req_ready[grant_id] = (!tx_valid || tx_ready), combinational. All other req_ready bits = 0.
  - Transfer occurs when req_valid[g] && req_ready[g]. On transfer:
    - tx_data <= req_data slice g; tx_valid <= 1; burst_cnt++.
  - Release on a transfer with req_last[g]=1, or with burst_cnt+1 == MAX_BURST:
    - next state IDLE; rr_ptr <= (g+1) mod NUM_REQ.
  - The granted requester deasserting req_valid mid-packet does NOT release the grant; it is held indefinitely.
  - enable deasserted during GRANT: the current packet completes normally, then no new grants.
- Output register:
  - tx_valid clears when tx_ready=1 and no new transfer occurs in the same cycle.
  - A transfer in the same cycle as tx_ready=1 replaces the byte with no bubble, giving full throughput of 1 byte/cycle.
  - tx_data and tx_valid are stable while tx_valid=1 and tx_ready=0.
  - tx_valid may still be 1 in IDLE while the last byte drains. Arbitration proceeds regardless; the next grant's req_ready waits on tx_ready.
- Latency: req_valid rising in IDLE at cycle 0 → grant at the edge ending cycle 0 → req_ready=1 in cycle 1 (if tx is free) → tx_valid=1 in cycle 2.
- Fairness:
  - rr_ptr advances only on release, to one past the released requester.
  - Any continuously requesting requester is granted within NUM_REQ-1 other grants.
- Width rules:
  - burst_cnt is 8 bits.
  - rr_ptr and grant_id wrap modulo NUM_REQ; non-power-of-2 NUM_REQ wraps explicitly to 0 from NUM_REQ-1.
- busy=1 exactly while state=GRANT.

Test Plan:
- Single requester: reset, req_valid[0]=1, tx_ready=1, 3 bytes 0x41, 0x42, 0x43 with req_last on 0x43 → tx_valid first high in cycle 2; tx sequence 41, 42, 43 back-to-back; busy drops the cycle after 0x43 is accepted; grant_id=0.
- Round-robin: all 4 requesters each send 1-byte packets (last=1) continuously → grant order 0, 1, 2, 3, 0, 1; no requester granted twice before the others.
- Backpressure: tx_ready=0 for 5 cycles while tx_valid=1, tx_data=0x55 → tx_data held at 0x55; req_ready[g]=0 throughout; resume with no byte lost or duplicated.
- Burst limit: MAX_BURST=16; req 1 streams 40 bytes with no last while req 2 is valid → req 1 is released after exactly 16 bytes, req 2 is granted next; req 1 is re-granted later and continues byte 17.
- Enable off mid-packet: enable=0 after byte 2 of a 4-byte packet → all 4 bytes are sent, then state stays IDLE with req_valid pending; enable=1 → grant in 1 cycle.
- Async reset: ARESETN low mid-packet with tx_valid=1 → tx_valid, req_ready, busy and grant_id go to 0 immediately, without waiting for an ACLK edge; after release, the first grant goes to the lowest-index valid requester.
